// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Fetch-controller state encoding, PC defaults and HALT opcode.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_hold   = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN    = c_st_run,
        ST_HOLD   = c_st_hold,
        ST_HALTED = c_st_halted
    } fetch_state_e;

    localparam int unsigned c_pc_inc_default   = 1;
    localparam int unsigned c_reset_pc_default = 0;

    // Primary opcode the decoder matches to raise i_halt.
    localparam logic [5:0]  c_halt_opcode      = 6'b111111;

endpackage
`default_nettype wire

// File: rtl/pc_redirect_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_buffer
// Description : Holds one redirect target raised while the pipeline stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_reset,
    input  wire logic                  i_enable,
    input  wire logic                  i_stall,
    input  wire logic                  i_branch,
    input  wire logic [DATA_WIDTH-1:0] i_pcbranch,
    input  wire logic                  i_jump,
    input  wire logic [DATA_WIDTH-1:0] i_pcjump,
    output logic                       o_valid,
    output logic [DATA_WIDTH-1:0]      o_target
);

    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_target_q;
    logic                  w_valid_d;
    logic [DATA_WIDTH-1:0] w_target_d;

    // A branch always (re)captures; a jump only fills an empty buffer since a
    // buffered entry is either the same jump re-presented or older than it.
    always_comb begin
        w_valid_d  = r_valid_q;
        w_target_d = r_target_q;
        if (i_enable) begin
            if (i_stall) begin
                if (i_branch) begin
                    w_valid_d  = 1'b1;
                    w_target_d = i_pcbranch;
                end else if (!r_valid_q && i_jump) begin
                    w_valid_d  = 1'b1;
                    w_target_d = i_pcjump;
                end
            end else begin
                w_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_valid_q  <= 1'b0;
            r_target_q <= '0;
        end else begin
            r_valid_q  <= w_valid_d;
            r_target_q <= w_target_d;
        end
    end

    assign o_valid  = r_valid_q;
    assign o_target = r_target_q;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : IF-stage PC sequencer with branch/jump redirect, stall
//               buffering and HALT. Define PC_REDIRECT_CNT_EN to add the
//               redirect/stall debug counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
    import pipeline_pkg::*;
#(
    parameter int                     DATA_WIDTH = 32,
    parameter int unsigned            PC_INC     = c_pc_inc_default,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = DATA_WIDTH'(c_reset_pc_default)
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_reset,
    input  wire logic                  i_enable,
    input  wire logic                  i_stall,
    input  wire logic                  i_jump,
    input  wire logic [DATA_WIDTH-1:0] i_pcjump,
    input  wire logic                  i_branch,
    input  wire logic [DATA_WIDTH-1:0] i_pcbranch,
    input  wire logic                  i_halt,
    output logic [DATA_WIDTH-1:0]      o_pc,
    output logic [DATA_WIDTH-1:0]      o_pc_next,
    output logic                       o_flush,
    output logic                       o_halted
`ifdef PC_REDIRECT_CNT_EN
    ,
    output logic [15:0]                o_redirect_count,
    output logic [15:0]                o_stall_count
`endif
);

    fetch_state_e          r_state_q, w_state_d;
    logic [DATA_WIDTH-1:0] r_pc_q, w_pc_d;
    logic                  r_flush_q, w_flush_d;
    logic                  r_halted_q, w_halted_d;
    logic                  w_active;
    logic                  w_buf_valid;
    logic [DATA_WIDTH-1:0] w_buf_target;
    logic [DATA_WIDTH-1:0] w_pc_inc;

    assign w_active  = i_enable && (r_state_q != ST_HALTED);
    assign w_pc_inc  = r_pc_q + DATA_WIDTH'(PC_INC);

    pc_redirect_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_redirect_buffer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_enable   (w_active),
        .i_stall    (i_stall),
        .i_branch   (i_branch),
        .i_pcbranch (i_pcbranch),
        .i_jump     (i_jump),
        .i_pcjump   (i_pcjump),
        .o_valid    (w_buf_valid),
        .o_target   (w_buf_target)
    );

    // Branch beats jump (older instruction); any redirect beats HALT, which is
    // then on the wrong path.
    always_comb begin
        w_state_d  = r_state_q;
        w_pc_d     = r_pc_q;
        w_flush_d  = 1'b0;
        w_halted_d = r_halted_q;
        if (i_enable) begin
            case (r_state_q)
                ST_RUN: begin
                    if (i_stall) begin
                        if (i_branch || i_jump) begin
                            w_state_d = ST_HOLD;
                        end
                    end else if (i_branch) begin
                        w_pc_d    = i_pcbranch;
                        w_flush_d = 1'b1;
                    end else if (i_jump) begin
                        w_pc_d    = i_pcjump;
                        w_flush_d = 1'b1;
                    end else if (i_halt) begin
                        w_state_d  = ST_HALTED;
                        w_halted_d = 1'b1;
                    end else begin
                        w_pc_d = w_pc_inc;
                    end
                end
                ST_HOLD: begin
                    if (!i_stall) begin
                        w_state_d = ST_RUN;
                        w_flush_d = 1'b1;
                        if (i_branch) begin
                            w_pc_d = i_pcbranch;
                        end else if (w_buf_valid) begin
                            w_pc_d = w_buf_target;
                        end
                    end
                end
                ST_HALTED: begin
                    w_state_d = ST_HALTED;
                end
                default: begin
                    w_state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state_q  <= ST_RUN;
            r_pc_q     <= RESET_PC;
            r_flush_q  <= 1'b0;
            r_halted_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_flush_q  <= w_flush_d;
            r_halted_q <= w_halted_d;
        end
    end

    assign o_pc      = r_pc_q;
    assign o_pc_next = w_pc_inc;
    assign o_flush   = r_flush_q;
    assign o_halted  = r_halted_q;

`ifdef PC_REDIRECT_CNT_EN
    logic [15:0] r_redir_cnt_q, w_redir_cnt_d;
    logic [15:0] r_stall_cnt_q, w_stall_cnt_d;

    // Both counters saturate so the debug unit never sees a wrap.
    always_comb begin
        w_redir_cnt_d = r_redir_cnt_q;
        w_stall_cnt_d = r_stall_cnt_q;
        if (w_flush_d && (r_redir_cnt_q != 16'hFFFF)) begin
            w_redir_cnt_d = r_redir_cnt_q + 16'd1;
        end
        if (w_active && i_stall && (r_stall_cnt_q != 16'hFFFF)) begin
            w_stall_cnt_d = r_stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_redir_cnt_q <= 16'd0;
            r_stall_cnt_q <= 16'd0;
        end else begin
            r_redir_cnt_q <= w_redir_cnt_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign o_redirect_count = r_redir_cnt_q;
    assign o_stall_count    = r_stall_cnt_q;
`endif

endmodule
`default_nettype wire
